serial_bus_arbiter: RTL and testbench

Parametrised shared-bus transmitter for the multi-node FPGA link. It arbitrates round-robin among `N_NODES` local senders and latches the winner's destination address and payload. It serialises one frame at a time onto the single-wire `bus_show` line and generates the frame CRC in hardware instead of taking it from the sender. It sits between the per-node request logic and the bus pin.

---
 rtl/bus_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/serial_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus transmitter.
//   state_t          : transmitter FSM states (one per frame field plus IDLE/GAP)
//   FLD_*            : frame field order on the wire, first to last
//   CRC_POLY_DEFAULT : x^4+x+1 without the top term
//   frame_len()      : total frame length in bits for a given parameter set
//   max3()           : helper used to size the per-field bit counter
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SRC,
        ST_DST,
        ST_DATA,
        ST_CRC,
        ST_GAP
    } state_t;

    localparam int FLD_START = 0;
    localparam int FLD_SRC   = 1;
    localparam int FLD_DST   = 2;
    localparam int FLD_DATA  = 3;
    localparam int FLD_CRC   = 4;

    localparam logic [3:0] CRC_POLY_DEFAULT = 4'h3;

    function automatic int frame_len(input int addr_w, input int data_w, input int crc_w);
        return 1 + 2 * addr_w + data_w + crc_w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req     : per-node request bits
//   ptr     : node with highest priority this round (must be < N_NODES)
//   win_oh  : one-hot winner, zero when no request
//   win_idx : winner index
//   win_vld : at least one request present
// The search starts at ptr and walks upward with wrap-around; the pointer
// register itself lives in the parent.
module rr_arbiter #(
    parameter int N_NODES = 16,
    parameter int IDX_W   = $clog2(N_NODES)
) (
    input  logic [N_NODES-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_NODES-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    int               jj;
    logic [IDX_W-1:0] j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        jj      = 0;
        j       = '0;
        for (int k = 0; k < N_NODES; k++) begin
            jj = int'(ptr) + k;
            if (jj >= N_NODES) jj = jj - N_NODES;
            j = IDX_W'(jj);
            if (!win_vld && req[j]) begin
                win_vld    = 1'b1;
                win_idx    = j;
                win_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin shared-bus transmitter.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   req          : per-node transmit request (level)
//   data_in      : node i payload at [i*DATA_W +: DATA_W]
//   dest_addr    : node i destination at [i*ADDR_W +: ADDR_W]
//   grant        : one-cycle one-hot pulse with the start bit of node i's frame
//   done         : one-cycle one-hot pulse with the last CRC bit of node i's frame
//   bus_show     : registered serial line, frame MSB-first
//   bus_valid    : a frame bit is on bus_show
//   busy         : FSM is not in IDLE
// Frame: 1 | src | dst | payload | crc, followed by one idle GAP cycle.
// state_q/cnt_q always describe the bit currently on bus_show; the next bit
// is computed combinationally and registered, so bus_show has no comb path.
module serial_bus_arbiter
    import bus_pkg::*;
#(
    parameter int               N_NODES  = 16,
    parameter int               ADDR_W   = 4,
    parameter int               DATA_W   = 64,
    parameter int               CRC_W    = 4,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEFAULT)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_NODES-1:0]          req,
    input  logic [N_NODES*DATA_W-1:0]   data_in,
    input  logic [N_NODES*ADDR_W-1:0]   dest_addr,
    output logic [N_NODES-1:0]          grant,
    output logic [N_NODES-1:0]          done,
    output logic                        bus_show,
    output logic                        bus_valid,
    output logic                        busy
);

    localparam int IDX_W  = $clog2(N_NODES);
    localparam int MSG_W  = 2 * ADDR_W + DATA_W;
    localparam int MAX_FW = max3(ADDR_W, DATA_W, CRC_W);
    localparam int CNT_W  = (MAX_FW > 1) ? $clog2(MAX_FW) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [IDX_W-1:0]   src_q,   src_d;
    logic [MSG_W-1:0]   msg_q,   msg_d;
    logic [CRC_W-1:0]   crc_q,   crc_d;
    logic               bus_q,   bus_d;
    logic               vld_q,   vld_d;
    logic [N_NODES-1:0] grant_q, grant_d;
    logic [N_NODES-1:0] done_q,  done_d;

    logic [N_NODES-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [DATA_W-1:0]  data_sel;
    logic [ADDR_W-1:0]  dest_sel;

    rr_arbiter #(
        .N_NODES (N_NODES),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Winner's payload/destination, selected with constant slices.
    always_comb begin
        data_sel = '0;
        dest_sel = '0;
        for (int i = 0; i < N_NODES; i++) begin
            if (win_oh[i]) begin
                data_sel = data_in[i*DATA_W +: DATA_W];
                dest_sel = dest_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    logic last, shift_msg, shift_crc, fb;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        msg_d     = msg_q;
        crc_d     = crc_q;
        bus_d     = 1'b0;
        vld_d     = 1'b0;
        grant_d   = '0;
        done_d    = '0;
        shift_msg = 1'b0;
        shift_crc = 1'b0;
        fb        = 1'b0;

        case (state_q)
            ST_SRC, ST_DST: last = (cnt_q == CNT_W'(ADDR_W - 1));
            ST_DATA:        last = (cnt_q == CNT_W'(DATA_W - 1));
            ST_CRC:         last = (cnt_q == CNT_W'(CRC_W - 1));
            default:        last = 1'b1;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    ptr_d   = (win_idx == IDX_W'(N_NODES - 1)) ? '0 : win_idx + IDX_W'(1);
                    src_d   = win_idx;
                    msg_d   = {ADDR_W'(win_idx), dest_sel, data_sel};
                    crc_d   = '0;
                    bus_d   = 1'b1;
                    vld_d   = 1'b1;
                    grant_d = win_oh;
                end
            end
            ST_START: begin
                state_d   = ST_SRC;
                cnt_d     = '0;
                shift_msg = 1'b1;
            end
            ST_SRC, ST_DST: begin
                shift_msg = 1'b1;
                if (last) begin
                    state_d = (state_q == ST_SRC) ? ST_DST : ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (last) begin
                    state_d   = ST_CRC;
                    cnt_d     = '0;
                    shift_crc = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    shift_msg = 1'b1;
                end
            end
            ST_CRC: begin
                if (last) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    shift_crc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Each message bit enters the LFSR as it is loaded onto the line, so
        // the CRC is complete by the time the last payload bit is showing.
        if (shift_msg) begin
            bus_d = msg_q[MSG_W-1];
            vld_d = 1'b1;
            msg_d = msg_q << 1;
            fb    = msg_q[MSG_W-1] ^ crc_q[CRC_W-1];
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        if (shift_crc) begin
            bus_d = crc_q[CRC_W-1];
            vld_d = 1'b1;
            crc_d = crc_q << 1;
            if (cnt_d == CNT_W'(CRC_W - 1)) done_d = N_NODES'(1) << src_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            src_q   <= '0;
            msg_q   <= '0;
            crc_q   <= '0;
            bus_q   <= 1'b0;
            vld_q   <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            msg_q   <= msg_d;
            crc_q   <= crc_d;
            bus_q   <= bus_d;
            vld_q   <= vld_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign bus_show  = bus_q;
    assign bus_valid = vld_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: directed scenarios plus randomized rounds,
// checked against a frame/arbitration model built from the protocol rules.
module tb_serial_bus_arbiter;
    import bus_pkg::*;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int CW = 4;
    localparam int L  = frame_len(AW, DW, CW);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [DW-1:0] nd [N];
    logic [AW-1:0] na [N];
    logic [N*DW-1:0] data_in;
    logic [N*AW-1:0] dest_addr;
    logic [N-1:0]  grant, done;
    logic          bus_show, bus_valid, busy;

    int     nvec = 0;
    int     nerr = 0;
    int     mptr = 0;
    longint cyc  = 0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign data_in[g*DW +: DW]   = nd[g];
        assign dest_addr[g*AW +: AW] = na[g];
    end

    serial_bus_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .dest_addr (dest_addr),
        .grant     (grant),
        .done      (done),
        .bus_show  (bus_show),
        .bus_valid (bus_valid),
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference CRC: x^4+x+1 LFSR over the 72 message bits, MSB first.
    function automatic logic [3:0] golden_crc(input logic [71:0] msg_in);
        logic [3:0]  c;
        logic [71:0] m;
        logic        f;
        c = '0;
        m = msg_in;
        for (int i = 0; i < 72; i++) begin
            f = m[71] ^ c[3];
            c = {c[2:0], 1'b0} ^ (f ? 4'h3 : 4'h0);
            m = m << 1;
        end
        return c;
    endfunction

    function automatic logic [127:0] build_frame(input int src, input logic [3:0] dst,
                                                 input logic [63:0] d);
        logic [71:0] msg;
        msg = {4'(src), dst, d};
        return 128'({1'b1, msg, golden_crc(msg)});
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (ptr + k) % N;
            if (((r >> j) & 16'd1) != 16'd0) return j;
        end
        return -1;
    endfunction

    // Waits (bounded) for a grant, then captures and checks one whole frame
    // plus the following GAP cycle. Returns at the GAP negedge.
    task automatic do_frame(input int exp_idx, input bit chg, output logic [127:0] fr,
                            output int lat, output longint tg);
        logic [127:0] exp_fr;
        logic [N-1:0] oh, dsum;
        int vcnt, dcnt;
        fr  = '0;
        lat = 0;
        tg  = 0;
        while (grant == '0 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        if (grant == '0) begin
            chk("grant_timeout", 128'(0), 128'(1));
            return;
        end
        tg     = cyc;
        oh     = 16'(1) << exp_idx;
        chk("grant", 128'(grant), 128'(oh));
        exp_fr = build_frame(exp_idx, na[exp_idx], nd[exp_idx]);
        vcnt = 0;
        dcnt = 0;
        dsum = '0;
        for (int b = 1; b <= L; b++) begin
            if (b > 1) @(negedge clock);
            fr = {fr[126:0], bus_show};
            if (bus_valid) vcnt++;
            if (done != '0) begin
                dcnt++;
                if (b == L) dsum = done;
            end
            if (chg && b == 2) begin
                req         = '0;
                nd[exp_idx] = ~nd[exp_idx];
                na[exp_idx] = ~na[exp_idx];
            end
        end
        chk("frame", fr, exp_fr);
        chk("valid_cnt", 128'(vcnt), 128'(L));
        chk("done_cnt", 128'(dcnt), 128'(1));
        chk("done_idx", 128'(dsum), 128'(oh));
        @(negedge clock);
        chk("gap", 128'({bus_show, bus_valid, busy, done}), 128'({1'b0, 1'b0, 1'b1, 16'h0}));
    endtask

    task automatic next_frame(input bit chg, output logic [127:0] fr, output int w,
                              output int lat, output longint tg);
        w    = rr_pick(req, mptr);
        mptr = (w + 1) % N;
        do_frame(w, chg, fr, lat, tg);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mptr  = 0;
    endtask

    task automatic rand_nodes();
        for (int i = 0; i < N; i++) begin
            nd[i] = {$urandom, $urandom};
            na[i] = 4'($urandom);
        end
    endtask

    initial begin
        logic [127:0] fr;
        logic [N-1:0] dsum;
        int     w, lat, n;
        longint tg, prev;

        for (int i = 0; i < N; i++) begin
            nd[i] = '0;
            na[i] = '0;
        end

        #1;
        chk("rst_out", 128'({grant, done, bus_show, bus_valid, busy}), 128'(0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_noreq", 128'({grant, bus_show, bus_valid, busy}), 128'(0));

        // All-zero frame from node 0.
        req = 16'h0001;
        next_frame(1'b0, fr, w, lat, tg);
        chk("grant_latency", 128'(lat), 128'(1));
        chk("allzero_frame", fr, 128'(1) << 76);
        req = '0;
        @(negedge clock);
        chk("idle_after", 128'({busy, bus_show, bus_valid}), 128'(0));

        // Payload 1, dest 1.
        nd[0] = 64'h1;
        na[0] = 4'h1;
        req   = 16'h0001;
        next_frame(1'b0, fr, w, lat, tg);
        chk("dst_field", 128'(fr[71:68]), 128'(4'h1));
        chk("last_payload", 128'(fr[4]), 128'(1'b1));
        chk("crc_field", 128'(fr[3:0]), 128'(golden_crc({4'h0, 4'h1, 64'h1})));
        req = '0;

        // Full contention: 17 frames, fixed spacing.
        pulse_reset();
        rand_nodes();
        req  = '1;
        prev = 0;
        for (int i = 0; i < 17; i++) begin
            next_frame(1'b0, fr, w, lat, tg);
            if (i > 0) chk("spacing", 128'(tg - prev), 128'(79));
            prev = tg;
        end
        req = '0;

        // Sparse requests 0 and 2.
        pulse_reset();
        req = 16'h0005;
        for (int i = 0; i < 4; i++) begin
            next_frame(1'b0, fr, w, lat, tg);
            chk("src_field", 128'(fr[75:72]), 128'(4'(w)));
        end
        req = '0;
        @(negedge clock);

        // Inputs change one cycle after grant; frame must be unaffected.
        req = 16'h0410;
        next_frame(1'b1, fr, w, lat, tg);
        @(negedge clock);
        chk("idle_after_drop", 128'({busy, bus_valid}), 128'(0));

        // Reset at bit 30 of a frame.
        req = 16'h0008;
        n   = 0;
        while (grant == '0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("mid_grant", 128'(grant), 128'(16'h0008));
        repeat (29) @(negedge clock);
        chk("pre_rst_valid", 128'({bus_valid, busy}), 128'(2'b11));
        reset = 1'b1;
        #1;
        chk("rst_async", 128'({bus_show, bus_valid, busy, grant, done}), 128'(0));
        dsum = '0;
        repeat (3) begin
            @(negedge clock);
            dsum = dsum | done;
        end
        chk("rst_no_done", 128'(dsum), 128'(0));
        reset = 1'b0;
        mptr  = 0;
        req   = 16'h0002;
        next_frame(1'b0, fr, w, lat, tg);
        req = '0;

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            rand_nodes();
            req = 16'($urandom_range(1, 65535));
            for (int f = 0; f < 3; f++) next_frame(1'b0, fr, w, lat, tg);
        end
        req = '0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
